// File: rtl/i2s_receiver.sv
// i2s_receiver: slave-mode I2S capture that turns an oversampled serial stream into
// one parallel left/right pair per frame, with valid and frame-error pulses.
module i2s_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  au_bck,
    input  logic                  au_ws,
    input  logic                  au_data,
    output logic [DATA_WIDTH-1:0] audio_left,
    output logic [DATA_WIDTH-1:0] audio_right,
    output logic                  sample_valid,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
    logic [SYNC_STAGES-1:0] bck_s, ws_s, dat_s;
    logic                   bck_d, rise, ws_v, dat_v, ws_chg;
    logic                   prev_ws, locked, left_pend, done, done_ws;
    logic [CW-1:0]          bitcnt, cnt_n, done_cnt;
    logic [DATA_WIDTH-1:0]  shreg, word_n, done_word, left_buf;

    assign ws_v   = ws_s[SYNC_STAGES-1];
    assign dat_v  = dat_s[SYNC_STAGES-1];
    assign ws_chg = ws_v != prev_ws;

    // bits beyond DATA_WIDTH in a long slot are dropped, the counter saturates
    always_comb begin
        cnt_n  = bitcnt < FULL ? bitcnt + CW'(1) : bitcnt;
        word_n = bitcnt < FULL ? {shreg[DATA_WIDTH-2:0], dat_v} : shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bck_s        <= '0;
            ws_s         <= '0;
            dat_s        <= '0;
            bck_d        <= 1'b0;
            rise         <= 1'b0;
            prev_ws      <= 1'b0;
            locked       <= 1'b0;
            left_pend    <= 1'b0;
            done         <= 1'b0;
            done_ws      <= 1'b0;
            done_cnt     <= '0;
            done_word    <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            left_buf     <= '0;
            audio_left   <= '0;
            audio_right  <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            bck_s        <= {bck_s[SYNC_STAGES-2:0], au_bck};
            ws_s         <= {ws_s[SYNC_STAGES-2:0], au_ws};
            dat_s        <= {dat_s[SYNC_STAGES-2:0], au_data};
            bck_d        <= bck_s[SYNC_STAGES-1];
            rise         <= bck_s[SYNC_STAGES-1] & ~bck_d;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (rise) begin
                shreg   <= word_n;
                prev_ws <= ws_v;
                bitcnt  <= ws_chg ? '0 : cnt_n;
                if (ws_chg) begin
                    done      <= 1'b1;
                    done_ws   <= prev_ws;
                    done_cnt  <= cnt_n;
                    done_word <= word_n;
                end
            end
            // slot-close decision runs one cycle after the closing bit is captured
            if (done) begin
                if (!locked) begin
                    locked <= 1'b1;
                end else if (done_cnt < FULL) begin
                    frame_err <= 1'b1;
                    left_pend <= 1'b0;
                end else if (!done_ws) begin
                    left_buf  <= done_word;
                    left_pend <= 1'b1;
                end else if (left_pend) begin
                    audio_left   <= left_buf;
                    audio_right  <= done_word;
                    sample_valid <= 1'b1;
                    left_pend    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S frames driven at bck = clk/8, checked against
// hand-computed words captured by a pulse monitor.
module tb_i2s_receiver;
    logic        clk, rst, au_bck, au_ws, au_data;
    logic [15:0] audio_left, audio_right;
    logic        sample_valid, frame_err;
    logic        pend, sv_d, fe_d;
    int          checks, failures, ecnt;
    logic [15:0] vl[$], vr[$];

    i2s_receiver dut (
        .clk(clk), .rst(rst), .au_bck(au_bck), .au_ws(au_ws), .au_data(au_data),
        .audio_left(audio_left), .audio_right(audio_right),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(logic ws, logic d);
        au_ws = ws;
        au_data = d;
        au_bck = 1'b0;
        tick(4);
        au_bck = 1'b1;
        tick(4);
    endtask

    // data lags ws by one BCK: each BCK carries the previous bit of the stream
    task automatic slot(logic ws, logic [15:0] w, int len, logic fill);
        for (int k = 0; k < len; k++) begin
            logic b;
            b = fill;
            if (k < 16) b = w[15-k];
            bit_out(ws, pend);
            pend = b;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid || frame_err) begin
            checks++;
            assert (!(sample_valid && frame_err) && !sv_d && !fe_d) else begin
                failures++;
                $error("FAIL pulse observed sv=%b fe=%b prev_sv=%b prev_fe=%b expected single 1-clk pulse",
                       sample_valid, frame_err, sv_d, fe_d);
            end
        end
        if (sample_valid) begin
            vl.push_back(audio_left);
            vr.push_back(audio_right);
        end
        if (frame_err) ecnt++;
        sv_d = sample_valid;
        fe_d = frame_err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst = 1; au_bck = 0; au_ws = 0; au_data = 0; pend = 0;
        sv_d = 0; fe_d = 0; checks = 0; failures = 0; ecnt = 0;
        repeat (3) begin
            @(negedge clk);
            au_bck = 1'($urandom);
            au_ws = 1'($urandom);
            au_data = 1'($urandom);
        end
        tick(1);
        chk("rst_left", audio_left, 0);
        chk("rst_right", audio_right, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_err", frame_err, 0);
        rst = 0; au_bck = 0; au_ws = 1; au_data = 0;
        tick(4);
        slot(1, 16'h0000, 16, 0);
        slot(0, 16'hA5C3, 16, 0);
        chk("lock_no_valid", vl.size(), 0);
        chk("lock_no_err", ecnt, 0);
        slot(1, 16'h3C5A, 16, 0);
        slot(0, 16'h8000, 16, 0);
        chk("f0_count", vl.size(), 1);
        chk("f0_left", vl[0], 16'hA5C3);
        chk("f0_right", vr[0], 16'h3C5A);
        chk("f0_out_left", audio_left, 16'hA5C3);
        chk("f0_out_right", audio_right, 16'h3C5A);
        chk("f0_err", ecnt, 0);
        slot(1, 16'h7FFF, 16, 0);
        slot(0, 16'hFFFF, 16, 0);
        slot(1, 16'h0000, 16, 0);
        slot(0, 16'h0001, 16, 0);
        slot(1, 16'hFFFE, 16, 0);
        slot(0, 16'h1234, 16, 0);
        slot(1, 16'h5678, 16, 0);
        slot(0, 16'h1234, 24, 1);
        chk("b2b_count", vl.size(), 5);
        chk("f1_left", vl[1], 16'h8000);
        chk("f1_right", vr[1], 16'h7FFF);
        chk("f2_left", vl[2], 16'hFFFF);
        chk("f2_right", vr[2], 16'h0000);
        chk("f3_left", vl[3], 16'h0001);
        chk("f3_right", vr[3], 16'hFFFE);
        chk("f4_left", vl[4], 16'h1234);
        chk("f4_right", vr[4], 16'h5678);
        slot(1, 16'hBEEF, 24, 1);
        slot(0, 16'h2222, 12, 0);
        chk("long_count", vl.size(), 6);
        chk("long_left", vl[5], 16'h1234);
        chk("long_right", vr[5], 16'hBEEF);
        chk("long_err", ecnt, 0);
        slot(1, 16'h1111, 16, 0);
        chk("short_err", ecnt, 1);
        chk("short_no_valid", vl.size(), 6);
        chk("short_hold_left", audio_left, 16'h1234);
        chk("short_hold_right", audio_right, 16'hBEEF);
        slot(0, 16'h6699, 16, 0);
        chk("orphan_right_dropped", vl.size(), 6);
        slot(1, 16'h9966, 16, 0);
        slot(0, 16'h0000, 16, 0);
        chk("recover_count", vl.size(), 7);
        chk("recover_left", vl[6], 16'h6699);
        chk("recover_right", vr[6], 16'h9966);
        chk("recover_err", ecnt, 1);
        slot(1, 16'hAAAA, 6, 0);
        rst = 1;
        tick(1);
        chk("midrst_left", audio_left, 0);
        chk("midrst_right", audio_right, 0);
        rst = 0;
        slot(1, 16'h5555, 10, 0);
        slot(0, 16'h0F0F, 16, 0);
        slot(1, 16'hF0F0, 16, 0);
        slot(0, 16'h0000, 2, 0);
        tick(10);
        chk("post_rst_count", vl.size(), 8);
        chk("post_rst_left", vl[7], 16'h0F0F);
        chk("post_rst_right", vr[7], 16'hF0F0);
        chk("post_rst_out_left", audio_left, 16'h0F0F);
        chk("post_rst_out_right", audio_right, 16'hF0F0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
